// File: rtl/cc_pkg.sv
// Shared definitions for the CipherCore stream cipher path.
package cc_pkg;

  localparam logic [15:0] CC_LFSR_POLY = 16'hB400;
  localparam logic [15:0] CC_ZERO_SEED = 16'hACE1;

  typedef enum logic {
    UNKEYED = 1'b0,
    RUN     = 1'b1
  } cc_cipher_state_t;

  // Advance a right-shifting Galois LFSR by eight steps: one step per keystream bit.
  function automatic logic [15:0] lfsr_step8(input logic [15:0] state,
                                             input logic [15:0] poly);
    logic [15:0] s;
    s = state;
    for (int i = 0; i < 8; i++) begin
      s = s[0] ? ((s >> 1) ^ poly) : (s >> 1);
    end
    return s;
  endfunction

endpackage

// File: rtl/cc_byte_fifo.sv
// Small byte FIFO with flush; head is presented from the storage registers.
module cc_byte_fifo #(
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;
  // Drive zero when empty so the output is clean after reset or flush.
  assign dout = empty ? 8'h00 : mem_q[rd_ptr_q];

  // Storage array: written on accepted push only, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // Pointers and occupancy; pointers wrap naturally for power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cc_stream_cipher.sv
// LFSR-keyed XOR stream cipher between the UART receiver and a valid/ready consumer.
module cc_stream_cipher
  import cc_pkg::*;
#(
  parameter logic [15:0] LFSR_POLY  = CC_LFSR_POLY,
  parameter logic [15:0] ZERO_SEED  = CC_ZERO_SEED,
  parameter int          FIFO_DEPTH = 2,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_load,
  input  logic [15:0]      key,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             keyed,
  output logic             overflow,
  output logic [CNT_W-1:0] byte_count
);

  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  cc_cipher_state_t state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic [FCW-1:0]   fifo_count;
  logic             pop;
  logic             push_req;
  logic             push_ok;
  logic [7:0]       cipher;

  // A key load flushes the buffer, so any same-cycle pop or push is void.
  assign pop      = ~fifo_empty & out_ready & ~key_load;
  assign push_req = (state_q == RUN) & in_valid & ~key_load;
  assign push_ok  = push_req & (~fifo_full | pop);
  assign cipher   = in_data ^ lfsr_q[7:0];

  assign out_valid  = (fifo_count != '0);
  assign keyed      = (state_q == RUN);
  assign overflow   = ovf_q;
  assign byte_count = cnt_q;

  cc_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (key_load),
    .push  (push_ok),
    .pop   (pop),
    .din   (cipher),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next-state: keying, keystream advance on accepted bytes, drop detection.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (key_load) begin
      state_d = RUN;
      lfsr_d  = (key == 16'h0000) ? ZERO_SEED : key;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (push_req) begin
      if (push_ok) begin
        lfsr_d = lfsr_step8(lfsr_q, LFSR_POLY);
        cnt_d  = cnt_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNKEYED;
      lfsr_q  <= ZERO_SEED;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_cc_stream_cipher.sv
// Randomised and directed check of cc_stream_cipher against a queue-based model.
module tb_cc_stream_cipher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_load = 1'b0;
  logic [15:0] key = 16'h0000;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        keyed;
  logic        overflow;
  logic [15:0] byte_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state
  bit          m_keyed;
  logic [15:0] m_lfsr;
  logic [7:0]  m_q[$];
  bit          m_ovf;
  logic [15:0] m_cnt;

  cc_stream_cipher dut (
    .clk        (clk),
    .rst        (rst),
    .key_load   (key_load),
    .key        (key),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .keyed      (keyed),
    .overflow   (overflow),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_step8(input logic [15:0] s_in);
    logic [15:0] s;
    s = s_in;
    for (int b = 0; b < 8; b++) begin
      if (s[0]) s = (s >> 1) ^ 16'hB400;
      else      s = s >> 1;
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_step(input bit r, input bit kl, input logic [15:0] k,
                            input bit v, input logic [7:0] d, input bit rdy);
    bit was_full;
    bit popped;
    if (r) begin
      m_keyed = 0; m_lfsr = 16'hACE1; m_q = {}; m_ovf = 0; m_cnt = 0;
    end else if (kl) begin
      m_keyed = 1; m_lfsr = (k == 0) ? 16'hACE1 : k; m_q = {}; m_ovf = 0; m_cnt = 0;
    end else begin
      was_full = (m_q.size() == 2);
      popped   = (m_q.size() > 0) && rdy;
      if (popped) void'(m_q.pop_front());
      if (m_keyed && v) begin
        if (!was_full || popped) begin
          m_q.push_back(d ^ m_lfsr[7:0]);
          m_lfsr = ref_step8(m_lfsr);
          m_cnt  = m_cnt + 1;
        end else begin
          m_ovf = 1;
        end
      end
    end
  endtask

  // One clock of stimulus, then compare every output with the model.
  task automatic cycle(input bit r, input bit kl, input logic [15:0] k,
                       input bit v, input logic [7:0] d, input bit rdy);
    rst = r; key_load = kl; key = k; in_valid = v; in_data = d; out_ready = rdy;
    @(posedge clk);
    #1;
    cyc++;
    model_step(r, kl, k, v, d, rdy);
    chk("out_valid",  out_valid,  (m_q.size() > 0));
    chk("out_data",   out_data,   (m_q.size() > 0) ? m_q[0] : 8'h00);
    chk("keyed",      keyed,      m_keyed);
    chk("overflow",   overflow,   m_ovf);
    chk("byte_count", byte_count, m_cnt);
    $display("cyc %0d rst=%0b kl=%0b key=%h in=%0b/%h rdy=%0b -> ov=%0b od=%h kd=%0b of=%0b cnt=%0d",
             cyc, r, kl, k, v, d, rdy, out_valid, out_data, keyed, overflow, byte_count);
  endtask

  initial begin
    bit r, kl, v, rdy;
    logic [15:0] k;
    // Reset
    repeat (3) cycle(1, 0, 0, 0, 0, 0);
    chk("reset_out_data", out_data, 8'h00);

    // Bytes before any key are discarded silently
    cycle(0, 0, 0, 1, 8'h41, 1);
    chk("unkeyed_valid", out_valid, 1'b0);
    chk("unkeyed_cnt", byte_count, 16'd0);

    // Known-answer with key 0x1234
    cycle(0, 1, 16'h1234, 0, 0, 1);
    cycle(0, 0, 0, 1, 8'h41, 1);
    chk("kat_1234", out_data, 8'h75);
    chk("kat_1234_cnt", byte_count, 16'd1);
    cycle(0, 0, 0, 1, 8'h41, 1);
    cycle(0, 0, 0, 0, 0, 1);

    // Zero key substitutes the default seed
    cycle(0, 1, 16'h0000, 0, 0, 1);
    cycle(0, 0, 0, 1, 8'h00, 1);
    chk("kat_zero", out_data, 8'hE1);
    cycle(0, 0, 0, 0, 0, 1);

    // Overflow: three pushes into a stalled two-entry buffer
    cycle(0, 1, 16'h1234, 0, 0, 0);
    cycle(0, 0, 0, 1, 8'h41, 0);
    cycle(0, 0, 0, 1, 8'h42, 0);
    cycle(0, 0, 0, 1, 8'h43, 0);
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_cnt", byte_count, 16'd2);
    repeat (3) cycle(0, 0, 0, 0, 0, 1);

    // Full buffer with simultaneous push and pop: no overflow
    cycle(0, 1, 16'hBEEF, 0, 0, 0);
    cycle(0, 0, 0, 1, 8'h10, 0);
    cycle(0, 0, 0, 1, 8'h20, 0);
    cycle(0, 0, 0, 1, 8'h30, 1);
    chk("full_pushpop_ovf", overflow, 1'b0);
    repeat (3) cycle(0, 0, 0, 0, 0, 1);

    // Re-key mid-stream with a byte buffered and a byte arriving
    cycle(0, 0, 0, 1, 8'h55, 0);
    cycle(0, 1, 16'h1234, 1, 8'h66, 1);
    chk("rekey_empty", out_valid, 1'b0);
    chk("rekey_cnt", byte_count, 16'd0);
    cycle(0, 0, 0, 1, 8'h41, 0);
    chk("rekey_kat", out_data, 8'h75);

    // Reset mid-stream
    cycle(0, 0, 0, 1, 8'h77, 0);
    cycle(1, 0, 0, 1, 8'h88, 1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_keyed", keyed, 1'b0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 99) == 0);
      kl  = ($urandom_range(0, 29) == 0);
      k   = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      v   = ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 2) != 0);
      cycle(r, kl, k, v, 8'($urandom), rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
